text_cursor_ctrl: RTL and testbench
===================================

Name: text_cursor_ctrl

Overview:
Upstream command stage for the text-mode GPU: accepts CPU register writes (character, clear, colour, cursor position) over a valid/ready handshake and turns them into single-cell framebuffer write strobes. Owns the cursor and the current colour, and sequences the full-screen clear. Its FB_* outputs drive the framebuffer write port of the text renderer; its command input is fed by the CPU bus capture logic.

Parameters:
COLS, 80, character columns per row
ROWS, 60, character rows
LINE_STEP, 2, rows advanced per newline or line wrap
DEFAULT_COLOR, 3'b001, colour after reset ({B,G,R})

Ports:
CLK  in  1  pixel-domain clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  block can accept a command
CMD_ADDR  in  2  register select: 0 char, 1 clear, 2 colour, 3 cursor set
CMD_DATA  in  8  command payload
FB_WE  out  1  framebuffer write strobe, one cell per cycle
FB_ADDR  out  13  cell index = y*COLS + x
FB_DATA  out  11  {colour[2:0], char[7:0]}
CURSOR_X  out  7  current column
CURSOR_Y  out  6  current row
BUSY  out  1  clear in progress

Behaviour:
- Reset (async, any state incl. mid-clear): state IDLE, FB_WE=0, FB_ADDR=0, FB_DATA=0, CURSOR_X=0, CURSOR_Y=0, colour=DEFAULT_COLOR, BUSY=0. Clear in flight is abandoned.
- CMD_READY = (state==IDLE), combinational; 1 after reset. Command accepted on the rising edge where CMD_VALID && CMD_READY. Throughput in IDLE: one command per cycle.
- FB_WE, FB_ADDR, FB_DATA registered: a write caused by a command accepted at edge N is presented during cycle N+1 (FB_WE high for exactly that one cycle unless the next accepted command also writes).
- States: IDLE, CLEAR. IDLE->CLEAR on accepted clear; CLEAR->IDLE after last cell.
- ADDR 0, DATA 0x0A: y advances by LINE_STEP; x unchanged; no write.
- ADDR 0, DATA 0x0D: x=0; no write.
- ADDR 0, DATA 0x08: if x>0, x=x-1 and write {colour,0x20} at new (x,y); if x==0, no move, no write.
- ADDR 0, other: write {colour,DATA} at (x,y); if x==COLS-1 then x=0 and y advances by LINE_STEP, else x=x+1.
- Row advance: if y+LINE_STEP > ROWS-1, y wraps to 0 (no scroll); with defaults y=58 -> 0.
- ADDR 1: enter CLEAR; BUSY=1 from next cycle; writes FB_DATA=0 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle (4800 cycles default); on final write cycle returns to IDLE with cursor (0,0), BUSY=0. Colour preserved. Commands presented during CLEAR are held off (READY=0), not dropped.
- ADDR 2: colour=DATA[2:0]; affects writes from next accepted command onward.
- ADDR 3: DATA[7]=0 -> x=min(DATA[6:0], COLS-1); DATA[7]=1 -> y=min(DATA[5:0], ROWS-1). No write.
- CURSOR_X/Y reflect the cursor after each accepted command, updated on the accept edge.
- FB_ADDR computed as (y<<6)+(y<<4)+x for COLS=80; generic y*COLS+x elsewhere; width 13 bits, no overflow for ROWS*COLS<=8192.

Decomposition:
- Shared package gpu_pkg: COLS, ROWS, FB_ADDR_W, command codes (CMD_CHAR, CMD_CLEAR, CMD_COLOR, CMD_CURSOR), control chars (CH_LF=0x0A, CH_CR=0x0D, CH_BS=0x08, CH_SPACE=0x20), state encoding, DEFAULT_COLOR.
- Single module; no sub-module required (the clear sequencer is a counter inside the same FSM).

Test Plan:
- Reset, write char 'A' (0x41) -> cycle after accept FB_WE=1, FB_ADDR=0, FB_DATA=0x141; CURSOR_X=1.
- Set colour 3'b110, then write 'B' 80 times from (0,0) -> last write FB_ADDR=79, FB_DATA=0x642; cursor becomes (0,2).
- Cursor set y=58, x=5, send 0x0A -> cursor (5,0); send 0x0D -> (0,0); no FB_WE during either.
- Cursor (3,4), send 0x08 -> FB_ADDR=4*80+2=322, FB_DATA={colour,0x20}; cursor (2,4); at x=0 backspace gives no write.
- Clear with CMD_VALID held high on a following char -> READY=0 and BUSY=1 for 4800 cycles, addresses 0..4799 each written once with 0, then pending char written at address 0.
- Assert RST at clear cell 1000 -> FB_WE drops immediately, cursor (0,0), colour=001, READY=1 after release.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared constants and types for the text-mode GPU command path.
// Screen geometry, command codes, control characters, FSM states.
package gpu_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 60;
  localparam int LINE_STEP = 2;
  localparam int FB_ADDR_W = 13;
  localparam int FB_DATA_W = 11;
  localparam int X_W       = 7;
  localparam int Y_W       = 6;

  localparam logic [2:0] DEFAULT_COLOR = 3'b001;

  typedef enum logic [1:0] {
    CMD_CHAR   = 2'd0,
    CMD_CLEAR  = 2'd1,
    CMD_COLOR  = 2'd2,
    CMD_CURSOR = 2'd3
  } cmd_e;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/text_cursor_ctrl.sv
// Text-mode command stage: cursor, colour and clear sequencing,
// producing one registered framebuffer cell write per cycle.
module text_cursor_ctrl #(
  parameter int         COLS          = gpu_pkg::COLS,
  parameter int         ROWS          = gpu_pkg::ROWS,
  parameter int         LINE_STEP     = gpu_pkg::LINE_STEP,
  parameter logic [2:0] DEFAULT_COLOR = gpu_pkg::DEFAULT_COLOR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_ADDR,
  input  logic [7:0]  CMD_DATA,
  output logic        FB_WE,
  output logic [12:0] FB_ADDR,
  output logic [10:0] FB_DATA,
  output logic [6:0]  CURSOR_X,
  output logic [5:0]  CURSOR_Y,
  output logic        BUSY
);
  import gpu_pkg::*;

  localparam int          CELLS     = COLS * ROWS;
  localparam logic [12:0] LAST_CELL = 13'(CELLS - 1);
  localparam logic [6:0]  X_MAX     = 7'(COLS - 1);
  localparam logic [5:0]  Y_MAX     = 6'(ROWS - 1);

  state_e      state;
  logic [12:0] clr_cnt;
  logic [2:0]  color;
  logic        accept;

  logic [6:0]  nx;
  logic [5:0]  ny;
  logic [2:0]  ncolor;
  logic        nwr;
  logic [12:0] naddr;
  logic [7:0]  nchar;
  logic        nclear;

  function automatic logic [12:0] cell_addr(
    input logic [6:0] cx,
    input logic [5:0] cy
  );
    logic [12:0] yy;
    yy = 13'(cy);
    if (COLS == 80)
      return (yy << 6) + (yy << 4) + 13'(cx);
    return 13'(int'(cy) * COLS + int'(cx));
  endfunction

  // No scrolling: running off the bottom wraps to the top row.
  function automatic logic [5:0] next_row(
    input logic [5:0] cy
  );
    if (int'(cy) + LINE_STEP > ROWS - 1)
      return '0;
    return 6'(int'(cy) + LINE_STEP);
  endfunction

  assign CMD_READY = (state == ST_IDLE);
  assign accept    = CMD_VALID && CMD_READY;

  always_comb begin
    nx     = CURSOR_X;
    ny     = CURSOR_Y;
    ncolor = color;
    nwr    = 1'b0;
    naddr  = cell_addr(CURSOR_X, CURSOR_Y);
    nchar  = CMD_DATA;
    nclear = 1'b0;
    unique case (cmd_e'(CMD_ADDR))
      CMD_CHAR: begin
        unique case (1'b1)
          (CMD_DATA == CH_LF): ny = next_row(CURSOR_Y);
          (CMD_DATA == CH_CR): nx = '0;
          (CMD_DATA == CH_BS): begin
            if (CURSOR_X != '0) begin
              nx    = CURSOR_X - 7'd1;
              nwr   = 1'b1;
              naddr = cell_addr(nx, CURSOR_Y);
              nchar = CH_SPACE;
            end
          end
          default: begin
            nwr = 1'b1;
            if (CURSOR_X == X_MAX) begin
              nx = '0;
              ny = next_row(CURSOR_Y);
            end else begin
              nx = CURSOR_X + 7'd1;
            end
          end
        endcase
      end
      CMD_CLEAR: nclear = 1'b1;
      CMD_COLOR: ncolor = CMD_DATA[2:0];
      CMD_CURSOR: begin
        if (CMD_DATA[7])
          ny = (CMD_DATA[5:0] > Y_MAX) ? Y_MAX : CMD_DATA[5:0];
        else
          nx = (CMD_DATA[6:0] > X_MAX) ? X_MAX : CMD_DATA[6:0];
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      color    <= DEFAULT_COLOR;
      FB_WE    <= 1'b0;
      FB_ADDR  <= '0;
      FB_DATA  <= '0;
      CURSOR_X <= '0;
      CURSOR_Y <= '0;
      BUSY     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          FB_WE <= 1'b0;
          if (accept) begin
            CURSOR_X <= nx;
            CURSOR_Y <= ny;
            color    <= ncolor;
            FB_WE    <= nwr;
            if (nwr) begin
              FB_ADDR <= naddr;
              FB_DATA <= {color, nchar};
            end
            if (nclear) begin
              state   <= ST_CLEAR;
              BUSY    <= 1'b1;
              clr_cnt <= '0;
            end
          end
        end
        ST_CLEAR: begin
          FB_WE   <= 1'b1;
          FB_ADDR <= clr_cnt;
          FB_DATA <= '0;
          clr_cnt <= clr_cnt + 13'd1;
          if (clr_cnt == LAST_CELL) begin
            state    <= ST_IDLE;
            BUSY     <= 1'b0;
            CURSOR_X <= '0;
            CURSOR_Y <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl: vector table plus
// hand-written clear and reset-during-clear sequences.
module tb_text_cursor_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_ADDR;
  logic [7:0]  CMD_DATA;
  logic        FB_WE;
  logic [12:0] FB_ADDR;
  logic [10:0] FB_DATA;
  logic [6:0]  CURSOR_X;
  logic [5:0]  CURSOR_Y;
  logic        BUSY;

  int tests = 0;
  int fails = 0;

  text_cursor_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR),
    .CMD_DATA(CMD_DATA),
    .FB_WE(FB_WE),
    .FB_ADDR(FB_ADDR),
    .FB_DATA(FB_DATA),
    .CURSOR_X(CURSOR_X),
    .CURSOR_Y(CURSOR_Y),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  addr;
    logic [7:0]  data;
    logic        we;
    logic [12:0] fa;
    logic [10:0] fd;
    logic [6:0]  x;
    logic [5:0]  y;
  } vec_t;

  localparam int NV = 22;
  vec_t vt[NV];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [7:0] d);
    CMD_ADDR  = a;
    CMD_DATA  = d;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
  endtask

  initial begin
    vt[0]  = '{2'd0, 8'h41, 1'b1, 13'd0,    11'h141, 7'd1,  6'd0};
    vt[1]  = '{2'd2, 8'h06, 1'b0, 13'd0,    11'h000, 7'd1,  6'd0};
    vt[2]  = '{2'd3, 8'h00, 1'b0, 13'd0,    11'h000, 7'd0,  6'd0};
    vt[3]  = '{2'd3, 8'hBA, 1'b0, 13'd0,    11'h000, 7'd0,  6'd58};
    vt[4]  = '{2'd3, 8'h05, 1'b0, 13'd0,    11'h000, 7'd5,  6'd58};
    vt[5]  = '{2'd0, 8'h0A, 1'b0, 13'd0,    11'h000, 7'd5,  6'd0};
    vt[6]  = '{2'd0, 8'h0D, 1'b0, 13'd0,    11'h000, 7'd0,  6'd0};
    vt[7]  = '{2'd3, 8'h03, 1'b0, 13'd0,    11'h000, 7'd3,  6'd0};
    vt[8]  = '{2'd3, 8'h84, 1'b0, 13'd0,    11'h000, 7'd3,  6'd4};
    vt[9]  = '{2'd0, 8'h08, 1'b1, 13'd322,  11'h620, 7'd2,  6'd4};
    vt[10] = '{2'd3, 8'h00, 1'b0, 13'd0,    11'h000, 7'd0,  6'd4};
    vt[11] = '{2'd0, 8'h08, 1'b0, 13'd0,    11'h000, 7'd0,  6'd4};
    vt[12] = '{2'd3, 8'h7F, 1'b0, 13'd0,    11'h000, 7'd79, 6'd4};
    vt[13] = '{2'd0, 8'h5A, 1'b1, 13'd399,  11'h65A, 7'd0,  6'd6};
    vt[14] = '{2'd3, 8'hBF, 1'b0, 13'd0,    11'h000, 7'd0,  6'd59};
    vt[15] = '{2'd0, 8'h0A, 1'b0, 13'd0,    11'h000, 7'd0,  6'd0};
    vt[16] = '{2'd3, 8'hB9, 1'b0, 13'd0,    11'h000, 7'd0,  6'd57};
    vt[17] = '{2'd0, 8'h0A, 1'b0, 13'd0,    11'h000, 7'd0,  6'd59};
    vt[18] = '{2'd2, 8'h01, 1'b0, 13'd0,    11'h000, 7'd0,  6'd59};
    vt[19] = '{2'd0, 8'h41, 1'b1, 13'd4720, 11'h141, 7'd1,  6'd59};
    vt[20] = '{2'd3, 8'h4F, 1'b0, 13'd0,    11'h000, 7'd79, 6'd59};
    vt[21] = '{2'd0, 8'h43, 1'b1, 13'd4799, 11'h143, 7'd0,  6'd0};

    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_ADDR  = '0;
    CMD_DATA  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_we",    int'(FB_WE),     0);
    chk("rst_addr",  int'(FB_ADDR),   0);
    chk("rst_data",  int'(FB_DATA),   0);
    chk("rst_x",     int'(CURSOR_X),  0);
    chk("rst_y",     int'(CURSOR_Y),  0);
    chk("rst_busy",  int'(BUSY),      0);
    chk("rst_ready", int'(CMD_READY), 1);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_ready", i), int'(CMD_READY), 1);
      send(vt[i].addr, vt[i].data);
      chk($sformatf("v%0d_we", i), int'(FB_WE), int'(vt[i].we));
      if (vt[i].we) begin
        chk($sformatf("v%0d_addr", i), int'(FB_ADDR), int'(vt[i].fa));
        chk($sformatf("v%0d_data", i), int'(FB_DATA), int'(vt[i].fd));
      end
      chk($sformatf("v%0d_x", i), int'(CURSOR_X), int'(vt[i].x));
      chk($sformatf("v%0d_y", i), int'(CURSOR_Y), int'(vt[i].y));
    end

    // Fill one row in colour 6; the 80th char wraps to row 2.
    send(2'd2, 8'h06);
    send(2'd3, 8'h00);
    send(2'd3, 8'h80);
    for (int i = 0; i < 80; i++) begin
      send(2'd0, 8'h42);
      chk($sformatf("row_we%0d", i), int'(FB_WE), 1);
      chk($sformatf("row_addr%0d", i), int'(FB_ADDR), i);
      chk($sformatf("row_data%0d", i), int'(FB_DATA), 'h642);
    end
    chk("row_x", int'(CURSOR_X), 0);
    chk("row_y", int'(CURSOR_Y), 2);

    // Clear with a char held pending behind it.
    begin
      int nlow = 0;
      int nbusy = 0;
      int bad = 0;
      int exp_a = 0;
      bit done = 1'b0;
      bit acc = 1'b0;
      CMD_ADDR  = 2'd1;
      CMD_DATA  = 8'h00;
      CMD_VALID = 1'b1;
      @(posedge CLK);
      #1;
      CMD_ADDR = 2'd0;
      CMD_DATA = 8'h51;
      for (int c = 0; c < 6000 && !done; c++) begin
        if (c > 0) begin
          @(posedge CLK);
          #1;
          if (acc) CMD_VALID = 1'b0;
        end
        if (!CMD_READY) nlow++;
        if (BUSY) nbusy++;
        if (FB_WE) begin
          if (FB_DATA == '0) begin
            if (int'(FB_ADDR) != exp_a) bad++;
            exp_a++;
          end else begin
            chk("pend_addr", int'(FB_ADDR), 0);
            chk("pend_data", int'(FB_DATA), 'h651);
            done = 1'b1;
          end
        end
        if (CMD_READY && CMD_VALID) acc = 1'b1;
      end
      CMD_VALID = 1'b0;
      chk("clr_done",   int'(done), 1);
      chk("clr_nready", nlow,  4800);
      chk("clr_nbusy",  nbusy, 4800);
      chk("clr_cells",  exp_a, 4800);
      chk("clr_order",  bad,   0);
      chk("clr_x",      int'(CURSOR_X), 1);
      chk("clr_y",      int'(CURSOR_Y), 0);
    end

    // Reset lands in the middle of a clear.
    begin
      bit hit = 1'b0;
      send(2'd2, 8'h06);
      send(2'd3, 8'h05);
      send(2'd3, 8'h83);
      send(2'd1, 8'h00);
      for (int c = 0; c < 2000 && !hit; c++) begin
        @(posedge CLK);
        #1;
        if (FB_WE && FB_ADDR == 13'd1000) hit = 1'b1;
      end
      chk("mid_hit", int'(hit), 1);
      RST = 1'b1;
      #1;
      chk("mid_we",   int'(FB_WE),    0);
      chk("mid_x",    int'(CURSOR_X), 0);
      chk("mid_y",    int'(CURSOR_Y), 0);
      chk("mid_busy", int'(BUSY),     0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk("mid_ready", int'(CMD_READY), 1);
      send(2'd0, 8'h41);
      chk("mid_cwe",   int'(FB_WE),   1);
      chk("mid_caddr", int'(FB_ADDR), 0);
      chk("mid_cdata", int'(FB_DATA), 'h141);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
